// File: rtl/spi_arb_pkg.sv
// Shared constants for the SPI flash ownership arbiter:
// state encodings, idle bus levels and a guard-state helper.
package spi_arb_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CPU     = 3'd1;
   localparam logic [2:0] ST_GUARD_P = 3'd2;
   localparam logic [2:0] ST_PROG    = 3'd3;
   localparam logic [2:0] ST_GUARD_I = 3'd4;

   typedef struct packed {
      logic cs;
      logic clk;
      logic mosi;
   } spi_bus_t;

   localparam logic IDLE_CS   = 1'b1;
   localparam logic IDLE_CLK  = 1'b0;
   localparam logic IDLE_MOSI = 1'b0;

   localparam spi_bus_t SPI_IDLE =
      spi_bus_t'({IDLE_CS, IDLE_CLK, IDLE_MOSI});

   function automatic logic is_guard(input logic [2:0] s);
      return (s == ST_GUARD_P) || (s == ST_GUARD_I);
   endfunction

endpackage

// File: rtl/spi_flash_arbiter_if.sv
// Bundle of both SPI masters, the request lines and the
// flash-side pins; slave is the arbiter, master the surroundings.
interface spi_flash_arbiter_if;

   logic i_FT_CS;
   logic i_cpu_req;
   logic i_cpu_spi_clk;
   logic i_cpu_spi_mosi;
   logic i_cpu_spi_cs;
   logic i_prog_spi_clk;
   logic i_prog_spi_mosi;
   logic i_prog_spi_cs;
   logic o_cpu_grant;
   logic o_prog_grant;
   logic o_SPI_CLK;
   logic o_SPI_MOSI;
   logic o_SPI_CS;
   logic o_MRDY;
   logic o_busy;

   modport slave (
      input  i_FT_CS, i_cpu_req,
      input  i_cpu_spi_clk, i_cpu_spi_mosi, i_cpu_spi_cs,
      input  i_prog_spi_clk, i_prog_spi_mosi, i_prog_spi_cs,
      output o_cpu_grant, o_prog_grant,
      output o_SPI_CLK, o_SPI_MOSI, o_SPI_CS,
      output o_MRDY, o_busy
   );

   modport master (
      output i_FT_CS, i_cpu_req,
      output i_cpu_spi_clk, i_cpu_spi_mosi, i_cpu_spi_cs,
      output i_prog_spi_clk, i_prog_spi_mosi, i_prog_spi_cs,
      input  o_cpu_grant, o_prog_grant,
      input  o_SPI_CLK, o_SPI_MOSI, o_SPI_CS,
      input  o_MRDY, o_busy
   );

endinterface

// File: rtl/spi_flash_arbiter_signal_synchronizer.sv
// Multi-flop synchronizer for an asynchronous level input,
// with a configurable depth and reset level.
module signal_synchronizer #(
   parameter int   DEPTH     = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] sync;

   // shift the input through DEPTH flops
   always_ff @(posedge clk) begin
      if (reset)
         sync <= {DEPTH{RESET_VAL}};
      else
         sync <= {sync[DEPTH-2:0], d};
   end

   assign q = sync[DEPTH-1];

endmodule

// File: rtl/spi_flash_arbiter.sv
// Sequenced ownership of the SPI flash between the 6809 read
// controller and the FT2232 writer, with a CS guard on handover.
import spi_arb_pkg::*;

module spi_flash_arbiter #(
   parameter int SYNC_STAGES  = 2,
   parameter int GUARD_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   spi_flash_arbiter_if.slave bus
);

   localparam int CW = $clog2(GUARD_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(GUARD_CYCLES - 1);

   logic [2:0]    state;
   logic [2:0]    state_nx;
   logic [CW-1:0] cnt;
   logic          ft_cs_sync;
   logic          prog_req;
   logic          guard_done;
   logic          cpu_hold;
   logic          cpu_grant;
   logic          prog_grant;
   logic          busy;
   spi_bus_t      pins;

   signal_synchronizer #(
      .DEPTH     (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_ft_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus.i_FT_CS),
      .q     (ft_cs_sync)
   );

   assign prog_req   = ~ft_cs_sync;
   assign guard_done = (cnt == CNT_LAST);
   assign cpu_hold   = bus.i_cpu_req | ~bus.i_cpu_spi_cs;

   // next owner; handover only between transactions
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (prog_req)
               state_nx = ST_GUARD_P;
            else if (bus.i_cpu_req)
               state_nx = ST_CPU;
         end
         ST_GUARD_P: begin
            if (!prog_req)
               state_nx = ST_GUARD_I;
            else if (guard_done)
               state_nx = ST_PROG;
         end
         ST_PROG: begin
            if (!prog_req)
               state_nx = ST_GUARD_I;
         end
         ST_CPU: begin
            if (!cpu_hold)
               state_nx = ST_GUARD_I;
         end
         ST_GUARD_I: begin
            if (guard_done)
               state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // state register plus registered grants and busy
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         cpu_grant  <= 1'b0;
         prog_grant <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nx;
         cpu_grant  <= (state_nx == ST_CPU);
         prog_grant <= (state_nx == ST_PROG);
         busy       <= (state_nx != ST_IDLE);
      end
   end

   // guard counter restarts on every state change, saturates
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (state_nx != state)
         cnt <= '0;
      else if (is_guard(state) && !guard_done)
         cnt <= cnt + CW'(1);
   end

   // flash pins follow the owner combinationally
   always_comb begin
      pins = SPI_IDLE;
      case (state)
         ST_CPU: begin
            pins.cs   = bus.i_cpu_spi_cs;
            pins.clk  = bus.i_cpu_spi_clk;
            pins.mosi = bus.i_cpu_spi_mosi;
         end
         ST_PROG: begin
            pins.cs   = bus.i_prog_spi_cs;
            pins.clk  = bus.i_prog_spi_clk;
            pins.mosi = bus.i_prog_spi_mosi;
         end
         default: pins = SPI_IDLE;
      endcase
   end

   assign bus.o_SPI_CS     = pins.cs;
   assign bus.o_SPI_CLK    = pins.clk;
   assign bus.o_SPI_MOSI   = pins.mosi;
   assign bus.o_cpu_grant  = cpu_grant;
   assign bus.o_prog_grant = prog_grant;
   assign bus.o_busy       = busy;
   assign bus.o_MRDY       = reset |
                             ~(bus.i_cpu_req & (state != ST_CPU));

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter with SYNC_STAGES=2,
// GUARD_CYCLES=4; expected timings are hand-derived.
module tb_spi_flash_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   spi_flash_arbiter_if bus();

   spi_flash_arbiter #(
      .SYNC_STAGES  (2),
      .GUARD_CYCLES (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle_inputs();
      bus.i_FT_CS         = 1'b1;
      bus.i_cpu_req       = 1'b0;
      bus.i_cpu_spi_cs    = 1'b1;
      bus.i_cpu_spi_clk   = 1'b0;
      bus.i_cpu_spi_mosi  = 1'b0;
      bus.i_prog_spi_cs   = 1'b1;
      bus.i_prog_spi_clk  = 1'b0;
      bus.i_prog_spi_mosi = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      tick(2);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      bus.i_FT_CS        = 1'b0;
      bus.i_cpu_req      = 1'b1;
      bus.i_cpu_spi_cs   = 1'b0;
      bus.i_cpu_spi_clk  = 1'b1;
      bus.i_cpu_spi_mosi = 1'b1;
      tick(2);
      tests++;
      if ({bus.o_cpu_grant, bus.o_prog_grant} !== 2'b00) begin
         fails++;
         $display("FAIL rst_grants: got %b want 00",
                  {bus.o_cpu_grant, bus.o_prog_grant});
      end
      tests++;
      if ({bus.o_SPI_CS, bus.o_SPI_CLK, bus.o_SPI_MOSI} !== 3'b100) begin
         fails++;
         $display("FAIL rst_pins: got %b want 100",
                  {bus.o_SPI_CS, bus.o_SPI_CLK, bus.o_SPI_MOSI});
      end
      tests++;
      if ({bus.o_MRDY, bus.o_busy} !== 2'b10) begin
         fails++;
         $display("FAIL rst_mrdy_busy: got %b want 10",
                  {bus.o_MRDY, bus.o_busy});
      end
      reset = 1'b0;
      bus.i_cpu_req       = 1'b0;
      bus.i_cpu_spi_cs    = 1'b1;
      bus.i_cpu_spi_clk   = 1'b0;
      bus.i_cpu_spi_mosi  = 1'b0;
      bus.i_prog_spi_cs   = 1'b0;
      bus.i_prog_spi_clk  = 1'b1;
      bus.i_prog_spi_mosi = 1'b1;
      tick(2);
      tests++;
      if (bus.o_busy !== 1'b0) begin
         fails++;
         $display("FAIL sync_delay_busy: got %b want 0", bus.o_busy);
      end
      tick(4);
      tests++;
      if ({bus.o_prog_grant, bus.o_busy, bus.o_SPI_CS} !== 3'b011) begin
         fails++;
         $display("FAIL guard_p_cycle6: got %b want 011",
                  {bus.o_prog_grant, bus.o_busy, bus.o_SPI_CS});
      end
      tick(1);
      tests++;
      if (bus.o_prog_grant !== 1'b1) begin
         fails++;
         $display("FAIL prog_latency7: got %b want 1", bus.o_prog_grant);
      end
      tests++;
      if ({bus.o_SPI_CS, bus.o_SPI_CLK, bus.o_SPI_MOSI} !== 3'b011) begin
         fails++;
         $display("FAIL prog_pins: got %b want 011",
                  {bus.o_SPI_CS, bus.o_SPI_CLK, bus.o_SPI_MOSI});
      end
   endtask

   task automatic test_cpu_grant();
      do_reset();
      bus.i_cpu_req = 1'b1;
      #1;
      tests++;
      if ({bus.o_MRDY, bus.o_cpu_grant} !== 2'b00) begin
         fails++;
         $display("FAIL cpu_req_stall: got %b want 00",
                  {bus.o_MRDY, bus.o_cpu_grant});
      end
      tick(1);
      tests++;
      if ({bus.o_cpu_grant, bus.o_MRDY, bus.o_prog_grant} !== 3'b110) begin
         fails++;
         $display("FAIL cpu_grant1: got %b want 110",
                  {bus.o_cpu_grant, bus.o_MRDY, bus.o_prog_grant});
      end
      bus.i_cpu_spi_cs   = 1'b0;
      bus.i_cpu_spi_clk  = 1'b1;
      bus.i_cpu_spi_mosi = 1'b1;
      #1;
      tests++;
      if ({bus.o_SPI_CS, bus.o_SPI_CLK, bus.o_SPI_MOSI} !== 3'b011) begin
         fails++;
         $display("FAIL cpu_pins_a: got %b want 011",
                  {bus.o_SPI_CS, bus.o_SPI_CLK, bus.o_SPI_MOSI});
      end
      bus.i_cpu_spi_clk = 1'b0;
      #1;
      tests++;
      if ({bus.o_SPI_CS, bus.o_SPI_CLK, bus.o_SPI_MOSI} !== 3'b001) begin
         fails++;
         $display("FAIL cpu_pins_b: got %b want 001",
                  {bus.o_SPI_CS, bus.o_SPI_CLK, bus.o_SPI_MOSI});
      end
      tick(3);
      bus.i_cpu_req = 1'b0;
      tick(1);
      tests++;
      if (bus.o_cpu_grant !== 1'b1) begin
         fails++;
         $display("FAIL cpu_cs_hold: got %b want 1", bus.o_cpu_grant);
      end
      bus.i_cpu_spi_cs   = 1'b1;
      bus.i_cpu_spi_mosi = 1'b0;
      tick(1);
      tests++;
      if ({bus.o_cpu_grant, bus.o_busy, bus.o_SPI_CS} !== 3'b011) begin
         fails++;
         $display("FAIL cpu_release: got %b want 011",
                  {bus.o_cpu_grant, bus.o_busy, bus.o_SPI_CS});
      end
      tick(3);
      tests++;
      if (bus.o_busy !== 1'b1) begin
         fails++;
         $display("FAIL guard_i_len3: got %b want 1", bus.o_busy);
      end
      tick(1);
      tests++;
      if (bus.o_busy !== 1'b0) begin
         fails++;
         $display("FAIL guard_i_len4: got %b want 0", bus.o_busy);
      end
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      do_reset();
      bus.i_cpu_req = 1'b1;
      tick(1);
      bus.i_cpu_req = 1'b0;
      tick(1);
      bus.i_cpu_req    = 1'b1;
      bus.i_cpu_spi_cs = 1'b0;
      #1;
      tests++;
      if ({bus.o_MRDY, bus.o_cpu_grant} !== 2'b00) begin
         fails++;
         $display("FAIL b2b_stall: got %b want 00",
                  {bus.o_MRDY, bus.o_cpu_grant});
      end
      for (int i = 1; i <= 4; i++) begin
         tick(1);
         if (bus.o_SPI_CS !== 1'b1 || bus.o_cpu_grant !== 1'b0 ||
             bus.o_MRDY !== 1'b0)
            bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL b2b_guard: got %0d bad cycles want 0", bad);
      end
      tick(1);
      tests++;
      if ({bus.o_cpu_grant, bus.o_SPI_CS, bus.o_MRDY} !== 3'b101) begin
         fails++;
         $display("FAIL b2b_regrant: got %b want 101",
                  {bus.o_cpu_grant, bus.o_SPI_CS, bus.o_MRDY});
      end
      idle_inputs();
   endtask

   task automatic test_no_preempt();
      int bad = 0;
      do_reset();
      bus.i_cpu_req = 1'b1;
      tick(1);
      bus.i_cpu_spi_cs    = 1'b0;
      bus.i_cpu_req       = 1'b0;
      bus.i_FT_CS         = 1'b0;
      bus.i_prog_spi_cs   = 1'b0;
      bus.i_prog_spi_clk  = 1'b1;
      bus.i_prog_spi_mosi = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (bus.o_cpu_grant !== 1'b1 || bus.o_prog_grant !== 1'b0)
            bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL no_preempt: got %0d bad cycles want 0", bad);
      end
      bus.i_cpu_spi_cs = 1'b1;
      tick(1);
      bad = (bus.o_SPI_CS !== 1'b1 || bus.o_cpu_grant !== 1'b0) ? 1 : 0;
      for (int i = 1; i <= 8; i++) begin
         tick(1);
         if (bus.o_SPI_CS !== 1'b1 || bus.o_prog_grant !== 1'b0)
            bad++;
         if (i == 4) begin
            tests++;
            if (bus.o_busy !== 1'b0) begin
               fails++;
               $display("FAIL np_idle_gap: got %b want 0", bus.o_busy);
            end
         end
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL np_guards_cs: got %0d bad cycles want 0", bad);
      end
      tick(1);
      tests++;
      if ({bus.o_prog_grant, bus.o_SPI_CS} !== 2'b10) begin
         fails++;
         $display("FAIL np_prog_grant: got %b want 10",
                  {bus.o_prog_grant, bus.o_SPI_CS});
      end
   endtask

   task automatic test_cpu_during_prog();
      int bad = 0;
      bus.i_cpu_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         bus.i_prog_spi_clk = ~bus.i_prog_spi_clk;
         #1;
         if (bus.o_MRDY !== 1'b0 ||
             bus.o_SPI_CLK !== bus.i_prog_spi_clk)
            bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL prog_sck_mrdy: got %0d bad cycles want 0", bad);
      end
      bus.i_FT_CS = 1'b1;
      bad = 0;
      for (int i = 1; i <= 7; i++) begin
         tick(1);
         if (bus.o_MRDY !== 1'b0 || bus.o_cpu_grant !== 1'b0)
            bad++;
         if (i == 2 && bus.o_prog_grant !== 1'b1)
            bad++;
         if (i == 3 && bus.o_prog_grant !== 1'b0)
            bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL cdp_stall: got %0d bad cycles want 0", bad);
      end
      tick(1);
      tests++;
      if ({bus.o_cpu_grant, bus.o_MRDY} !== 2'b11) begin
         fails++;
         $display("FAIL cdp_grant: got %b want 11",
                  {bus.o_cpu_grant, bus.o_MRDY});
      end
      idle_inputs();
      tick(1);
   endtask

   task automatic test_abort();
      int bad = 0;
      do_reset();
      bus.i_FT_CS = 1'b0;
      tick(2);
      bus.i_FT_CS = 1'b1;
      for (int i = 3; i <= 12; i++) begin
         tick(1);
         if (bus.o_prog_grant !== 1'b0)
            bad++;
         if ((i == 3 || i == 8) && bus.o_busy !== 1'b1)
            bad++;
         if (i == 9) begin
            tests++;
            if (bus.o_busy !== 1'b0) begin
               fails++;
               $display("FAIL abort_idle: got %b want 0", bus.o_busy);
            end
         end
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL abort_guard: got %0d bad cycles want 0", bad);
      end
   endtask

   task automatic test_reset_mid_prog();
      do_reset();
      bus.i_FT_CS = 1'b0;
      tick(7);
      bus.i_prog_spi_cs   = 1'b0;
      bus.i_prog_spi_clk  = 1'b1;
      bus.i_prog_spi_mosi = 1'b1;
      #1;
      tests++;
      if ({bus.o_prog_grant, bus.o_SPI_CLK} !== 2'b11) begin
         fails++;
         $display("FAIL rmp_prog: got %b want 11",
                  {bus.o_prog_grant, bus.o_SPI_CLK});
      end
      reset = 1'b1;
      tick(1);
      tests++;
      if ({bus.o_SPI_CS, bus.o_SPI_CLK, bus.o_SPI_MOSI} !== 3'b100) begin
         fails++;
         $display("FAIL rmp_pins: got %b want 100",
                  {bus.o_SPI_CS, bus.o_SPI_CLK, bus.o_SPI_MOSI});
      end
      tests++;
      if ({bus.o_cpu_grant, bus.o_prog_grant, bus.o_busy} !== 3'b000) begin
         fails++;
         $display("FAIL rmp_grants: got %b want 000",
                  {bus.o_cpu_grant, bus.o_prog_grant, bus.o_busy});
      end
      idle_inputs();
      reset = 1'b0;
      tick(1);
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_cpu_grant();
      test_back_to_back();
      test_no_preempt();
      test_cpu_during_prog();
      test_abort();
      test_reset_mid_prog();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
